// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory arbiter: FSM states, master ids,
// pending-slot payload and the default response watchdog limit.
package mem_arb_pkg;

   localparam int TIMEOUT_CYCLES_DEF = 256;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   typedef logic mst_id_t;

   localparam mst_id_t MST_M0 = 1'b0;
   localparam mst_id_t MST_M1 = 1'b1;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } slot_t;

endpackage

// File: rtl/arb_req_slot.sv
// One-entry pending request slot for a single master: captures a request
// pulse, holds it until the arbiter clears it, and flags overflow.
module arb_req_slot
   import mem_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        clr,
   output logic        full,
   output slot_t       slot,
   output logic        ovf
);

   logic accept;

   // A clear on the same edge frees the slot, so a back-to-back request is accepted.
   assign accept = req && (!full || clr);
   assign ovf    = req && full && !clr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full <= 1'b0;
      end else if (accept) begin
         full <= 1'b1;
      end else if (clr) begin
         full <= 1'b0;
      end
   end

   // Payload is only meaningful while full is set, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         slot <= '{we: we, be: be, addr: addr, wdata: wdata};
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (D-cache m0, I-cache m1) arbiter onto one memory port with a
// response watchdog. Define ARB_RR_EN for round-robin, else m0 has fixed priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [3:0]  m0_be,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_rvalid,
   output logic        m0_fault,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [3:0]  m1_be,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_rvalid,
   output logic        m1_fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   input  logic        mem_fault,
   output logic        arb_err
);

   localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   arb_state_t      state;
   mst_id_t         owner;
   mst_id_t         winner;
   logic [WD_W-1:0] wd_cnt;
   logic [1:0]      full;
   logic [1:0]      ovf;
   logic [1:0]      clr;
   slot_t           s0;
   slot_t           s1;
   slot_t           own_slot;
   logic            issue;
   logic            in_wait;
   logic            timeout;
   logic            rsp_any;
   logic            done;
   logic            own_rv;
   logic            own_ft;
   logic [31:0]     own_rd;

   arb_req_slot u_slot0 (
      .clk   (clk),
      .rst   (rst),
      .req   (m0_req),
      .we    (m0_we),
      .be    (m0_be),
      .addr  (m0_addr),
      .wdata (m0_wdata),
      .clr   (clr[0]),
      .full  (full[0]),
      .slot  (s0),
      .ovf   (ovf[0])
   );

   arb_req_slot u_slot1 (
      .clk   (clk),
      .rst   (rst),
      .req   (m1_req),
      .we    (m1_we),
      .be    (m1_be),
      .addr  (m1_addr),
      .wdata (m1_wdata),
      .clr   (clr[1]),
      .full  (full[1]),
      .slot  (s1),
      .ovf   (ovf[1])
   );

`ifdef ARB_RR_EN
   mst_id_t rr_ptr;
   assign winner = (full == 2'b11) ? rr_ptr : (full[1] ? MST_M1 : MST_M0);
`else
   assign winner = full[0] ? MST_M0 : MST_M1;
`endif

   assign in_wait = (state == ST_WAIT);
   assign timeout = in_wait && (wd_cnt == WD_LAST);
   assign rsp_any = in_wait && (mem_rvalid || mem_fault);
   assign done    = rsp_any || timeout;
   // A real response beats a coincident timeout; mem_fault beats mem_rvalid.
   assign own_ft  = in_wait && (mem_fault || (!mem_rvalid && timeout));
   assign own_rv  = in_wait && mem_rvalid && !mem_fault;
   assign own_rd  = rsp_any ? mem_rdata : '0;

   assign clr[0] = done && (owner == MST_M0);
   assign clr[1] = done && (owner == MST_M1);

   assign m0_rvalid = own_rv && (owner == MST_M0);
   assign m0_fault  = own_ft && (owner == MST_M0);
   assign m0_rdata  = (owner == MST_M0) ? own_rd : '0;
   assign m1_rvalid = own_rv && (owner == MST_M1);
   assign m1_fault  = own_ft && (owner == MST_M1);
   assign m1_rdata  = (owner == MST_M1) ? own_rd : '0;

   assign own_slot  = (owner == MST_M1) ? s1 : s0;
   assign issue     = (state == ST_ISSUE);
   assign mem_req   = issue;
   assign mem_we    = issue && own_slot.we;
   assign mem_be    = issue ? own_slot.be    : '0;
   assign mem_addr  = issue ? own_slot.addr  : '0;
   assign mem_wdata = issue ? own_slot.wdata : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         owner   <= MST_M0;
         wd_cnt  <= '0;
         arb_err <= 1'b0;
`ifdef ARB_RR_EN
         rr_ptr  <= MST_M0;
`endif
      end else begin
         arb_err <= |ovf;
         case (state)
            ST_IDLE: begin
               if (|full) begin
                  owner <= winner;
                  state <= ST_ISSUE;
`ifdef ARB_RR_EN
                  rr_ptr <= ~winner;
`endif
               end
            end
            ST_ISSUE: begin
               wd_cnt <= '0;
               state  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (done) begin
                  state <= ST_IDLE;
               end else begin
                  wd_cnt <= wd_cnt + WD_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int TO = 8;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } rq_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m_req [2];
   logic        m_we [2];
   logic [3:0]  m_be [2];
   logic [31:0] m_addr [2];
   logic [31:0] m_wdata [2];
   logic [31:0] m_rdata [2];
   logic        m_rvalid [2];
   logic        m_fault [2];
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;
   logic        mem_fault = 1'b0;
   logic        arb_err;

   // staged inputs, applied at the next falling edge
   logic        s_rst = 1'b1;
   logic        s_req [2];
   logic        s_we [2];
   logic [3:0]  s_be [2];
   logic [31:0] s_addr [2];
   logic [31:0] s_wdata [2];
   logic        s_mrv = 1'b0;
   logic        s_mft = 1'b0;
   logic [31:0] s_mrd = '0;
   bit          auto_mem = 1'b0;
   int          resp_at = -1;
   bit          resp_flt = 1'b0;

   // reference model state
   rq_t pq [2][$];
   bit  busy = 1'b0;
   int  own = 0;
   int  issue_at = 0;
   int  prio = 0;
   bit  err_n = 1'b0;
   int  cyc = 0;

   int  n_chk = 0;
   int  n_fail = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .m0_req     (m_req[0]),
      .m0_we      (m_we[0]),
      .m0_be      (m_be[0]),
      .m0_addr    (m_addr[0]),
      .m0_wdata   (m_wdata[0]),
      .m0_rdata   (m_rdata[0]),
      .m0_rvalid  (m_rvalid[0]),
      .m0_fault   (m_fault[0]),
      .m1_req     (m_req[1]),
      .m1_we      (m_we[1]),
      .m1_be      (m_be[1]),
      .m1_addr    (m_addr[1]),
      .m1_wdata   (m_wdata[1]),
      .m1_rdata   (m_rdata[1]),
      .m1_rvalid  (m_rvalid[1]),
      .m1_fault   (m_fault[1]),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_be     (mem_be),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_rvalid (mem_rvalid),
      .mem_fault  (mem_fault),
      .arb_err    (arb_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic stage_req(input int m, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
      s_req[m]   = 1'b1;
      s_we[m]    = we;
      s_be[m]    = be;
      s_addr[m]  = addr;
      s_wdata[m] = wdata;
   endtask

   function automatic int pick();
      if (pq[0].size() != 0 && pq[1].size() != 0) begin
`ifdef ARB_RR_EN
         return prio;
`else
         return 0;
`endif
      end
      return (pq[0].size() != 0) ? 0 : 1;
   endfunction

   // One clock cycle: apply staged inputs, compare outputs with the model, advance the model.
   task automatic step();
      logic [31:0] e_rd [2];
      logic        e_rv [2];
      logic        e_ft [2];
      logic        e_mreq, e_we, e_err;
      logic [3:0]  e_be;
      logic [31:0] e_addr, e_wd;
      bit          in_wait, tmo, done;
      int          age, win;
      @(negedge clk);
      if (auto_mem) begin
         s_mrv = (cyc == resp_at) || ($urandom_range(0, 59) == 0);
         s_mft = (cyc == resp_at) && resp_flt;
         s_mrd = $urandom;
      end
      rst        = s_rst;
      mem_rvalid = s_mrv;
      mem_fault  = s_mft;
      mem_rdata  = s_mrd;
      for (int m = 0; m < 2; m++) begin
         m_req[m]   = s_req[m];
         m_we[m]    = s_we[m];
         m_be[m]    = s_be[m];
         m_addr[m]  = s_addr[m];
         m_wdata[m] = s_wdata[m];
         s_req[m]   = 1'b0;
      end
      s_mrv = 1'b0;
      s_mft = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         e_rd[m] = '0;
         e_rv[m] = 1'b0;
         e_ft[m] = 1'b0;
      end
      e_mreq = 1'b0; e_we = 1'b0; e_be = '0; e_addr = '0; e_wd = '0; e_err = 1'b0;
      in_wait = 1'b0; tmo = 1'b0; done = 1'b0;
      if (!rst) begin
         in_wait = busy && (cyc > issue_at);
         age     = cyc - issue_at - 1;
         tmo     = in_wait && (age == TO - 1);
         done    = in_wait && (mem_rvalid || mem_fault || tmo);
         if (busy && cyc == issue_at && pq[own].size() != 0) begin
            e_mreq = 1'b1;
            e_we   = pq[own][0].we;
            e_be   = pq[own][0].be;
            e_addr = pq[own][0].addr;
            e_wd   = pq[own][0].wdata;
         end
         if (in_wait) begin
            e_rv[own] = mem_rvalid && !mem_fault;
            e_ft[own] = mem_fault || (!mem_rvalid && tmo);
            if (mem_rvalid || mem_fault) e_rd[own] = mem_rdata;
         end
         e_err = err_n;
      end
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("m%0d_rvalid", m), 32'(m_rvalid[m]), 32'(e_rv[m]));
         chk($sformatf("m%0d_fault", m),  32'(m_fault[m]),  32'(e_ft[m]));
         chk($sformatf("m%0d_rdata", m),  m_rdata[m],       e_rd[m]);
      end
      chk("mem_req",   32'(mem_req), 32'(e_mreq));
      chk("mem_we",    32'(mem_we),  32'(e_we));
      chk("mem_be",    32'(mem_be),  32'(e_be));
      chk("mem_addr",  mem_addr,     e_addr);
      chk("mem_wdata", mem_wdata,    e_wd);
      chk("arb_err",   32'(arb_err), 32'(e_err));
      if (rst) begin
         busy = 1'b0;
         pq[0].delete();
         pq[1].delete();
         prio  = 0;
         err_n = 1'b0;
      end else begin
         if (e_mreq && auto_mem) begin
            resp_at  = cyc + $urandom_range(1, 10);
            resp_flt = ($urandom_range(0, 5) == 0);
         end
         if (!busy && (pq[0].size() != 0 || pq[1].size() != 0)) begin
            win      = pick();
            busy     = 1'b1;
            own      = win;
            issue_at = cyc + 1;
            prio     = 1 - win;
         end
         if (done) begin
            pq[own].delete();
            busy = 1'b0;
         end
         err_n = 1'b0;
         for (int m = 0; m < 2; m++) begin
            if (m_req[m]) begin
               if (pq[m].size() != 0) err_n = 1'b1;
               else pq[m].push_back('{we: m_we[m], be: m_be[m], addr: m_addr[m], wdata: m_wdata[m]});
            end
         end
      end
      cyc++;
   endtask

   task automatic drain();
      auto_mem = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if (!busy && pq[0].size() == 0 && pq[1].size() == 0) break;
         step();
      end
      auto_mem = 1'b0;
      resp_at  = -1;
      step();
   endtask

   initial begin
      int ic, fc, errs, reqs;
      logic [31:0] seen;
      for (int m = 0; m < 2; m++) begin
         m_req[m] = 1'b0; m_we[m] = 1'b0; m_be[m] = '0; m_addr[m] = '0; m_wdata[m] = '0;
         s_req[m] = 1'b0; s_we[m] = 1'b0; s_be[m] = '0; s_addr[m] = '0; s_wdata[m] = '0;
      end

      // reset state
      s_rst = 1'b1;
      step();
      step();
      chk("t0_mem_req", 32'(mem_req), 32'd0);
      chk("t0_arb_err", 32'(arb_err), 32'd0);
      s_rst = 1'b0;
      step();

      // m1 read, response 3 cycles after mem_req
      stage_req(1, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
      step();
      step();
      chk("t1_req_n1", 32'(mem_req), 32'd0);
      step();
      chk("t1_req_n2", 32'(mem_req), 32'd1);
      chk("t1_addr", mem_addr, 32'h0000_1000);
      step();
      step();
      s_mrv = 1'b1; s_mrd = 32'hDEAD_BEEF;
      step();
      chk("t1_m1_rvalid", 32'(m_rvalid[1]), 32'd1);
      chk("t1_m1_rdata", m_rdata[1], 32'hDEAD_BEEF);
      chk("t1_m0_rdata", m_rdata[0], 32'd0);
      chk("t1_m0_rvalid", 32'(m_rvalid[0]), 32'd0);
      step();

      // m0 write queued behind outstanding m1
      stage_req(1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
      step(); step(); step();
      stage_req(0, 1'b1, 4'h3, 32'h0000_0010, 32'h0000_A5A5);
      step();
      step();
      s_mrv = 1'b1; s_mrd = 32'h1234_5678;
      step();
      chk("t2_m1_rvalid", 32'(m_rvalid[1]), 32'd1);
      step();
      chk("t2_idle_gap", 32'(mem_req), 32'd0);
      step();
      chk("t2_req", 32'(mem_req), 32'd1);
      chk("t2_we", 32'(mem_we), 32'd1);
      chk("t2_be", 32'(mem_be), 32'h3);
      chk("t2_addr", mem_addr, 32'h10);
      chk("t2_wdata", mem_wdata, 32'hA5A5);
      step();
      s_mrv = 1'b1;
      step();
      chk("t2_m0_rvalid", 32'(m_rvalid[0]), 32'd1);
      chk("t2_m1_quiet", 32'(m_rvalid[1]), 32'd0);
      step();

      // overflow: second m0 request while slot full
      stage_req(0, 1'b0, 4'hF, 32'h40, 32'h0);
      step();
      stage_req(0, 1'b0, 4'hF, 32'h80, 32'h0);
      step();
      errs = 0; reqs = 0; seen = '0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) s_mrv = 1'b1;
         step();
         errs += int'(arb_err);
         reqs += int'(mem_req);
         if (mem_req) seen = mem_addr;
      end
      chk("t3_err_cnt", 32'(errs), 32'd1);
      chk("t3_req_cnt", 32'(reqs), 32'd1);
      chk("t3_addr", seen, 32'h40);

      // watchdog with silent memory, then a late response
      stage_req(0, 1'b0, 4'hF, 32'h300, 32'h0);
      step();
      ic = -100; fc = -1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (mem_req) ic = cyc - 1;
         if (m_fault[0]) begin
            fc = cyc - 1;
            break;
         end
      end
      chk("t4_wd_latency", 32'(fc - ic), 32'd8);
      s_mrv = 1'b1; s_mrd = 32'hBAD0_0001;
      step();
      chk("t4_late_rvalid", 32'(m_rvalid[0]), 32'd0);
      step();

      // simultaneous requests; m0 re-requests on its own response cycle
      s_rst = 1'b1;
      step();
      s_rst = 1'b0;
      stage_req(0, 1'b0, 4'hF, 32'h500, 32'h0);
      stage_req(1, 1'b0, 4'hF, 32'h600, 32'h0);
      step(); step(); step();
      chk("t5_first_grant", mem_addr, 32'h500);
      step();
      s_mrv = 1'b1;
      stage_req(0, 1'b0, 4'hF, 32'h700, 32'h0);
      step();
      chk("t5_m0_done", 32'(m_rvalid[0]), 32'd1);
      step();
      step();
`ifdef ARB_RR_EN
      chk("t5_second_grant", mem_addr, 32'h600);
`else
      chk("t5_second_grant", mem_addr, 32'h700);
`endif
      drain();

      // reset while waiting, stale response afterwards
      stage_req(1, 1'b0, 4'hF, 32'h800, 32'h0);
      step(); step(); step(); step();
      s_rst = 1'b1;
      step();
      chk("t6_mem_req", 32'(mem_req), 32'd0);
      chk("t6_m1_fault", 32'(m_fault[1]), 32'd0);
      s_rst = 1'b0;
      s_mrv = 1'b1; s_mrd = 32'hFACE_0000;
      step();
      chk("t6_stale_rvalid", 32'(m_rvalid[1]), 32'd0);
      chk("t6_stale_rdata", m_rdata[1], 32'd0);
      step();

      // randomized traffic
      auto_mem = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         for (int m = 0; m < 2; m++) begin
            if ($urandom_range(0, 3) == 0)
               stage_req(m, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
         end
         s_rst = ($urandom_range(0, 399) == 0);
         step();
      end
      s_rst = 1'b0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
